// File: rtl/nios_interrupt_pio_pkg.sv
// Purpose : shared register map and edge-type encoding for the input PIO.
// Latency : n/a (constants and types only).
// Backpress: n/a.
package nios_interrupt_pio_pkg;

    // Avalon-MM word addresses; address 1 is unmapped and reads as zero.
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/nios_interrupt_pio_in_if.sv
// Purpose : Avalon-MM slave bus bundle for the input PIO.
// Latency : readdata is combinational from address.
// Backpress: none; every access completes in one cycle (no waitrequest).
// Ports   : address[1:0], chipselect, write_n, writedata[31:0] (master->slave),
//           readdata[31:0] (slave->master).
interface nios_interrupt_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_interrupt_pio_sync.sv
// Purpose : one-bit synchronizer chain with optional debounce filter
//           (build macro PIO_IN_DEBOUNCE_EN enables the debounce counter).
// Latency : SYNC_STAGES clocks, plus DEBOUNCE_CYCLES when debounce is built in.
// Backpress: none.
// Ports   : clk, reset (async active-high), pin (async input), level (accepted level).
module nios_interrupt_pio_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_param_err
        $error("nios_interrupt_pio_sync: SYNC_STAGES must be 2..4, DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          accepted;

    // The counter only runs while the synced value disagrees with the
    // accepted one; any return to agreement restarts the qualification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            accepted <= 1'b0;
        end else if (synced != accepted) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                accepted <= synced;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = accepted;
`else
    assign level = synced;
`endif

endmodule

// File: rtl/nios_interrupt_pio_in.sv
// Purpose : Avalon-MM input PIO: synced pin levels, sticky W1C edge capture,
//           maskable registered level irq (PIO_IN_DEBOUNCE_EN adds debounce).
// Latency : DATA after SYNC_STAGES clocks, capture +1, irq +2 (debounce adds
//           DEBOUNCE_CYCLES to all); readdata combinational.
// Backpress: none; single-cycle slave, no waitrequest.
// Ports   : clk, reset (async active-high), avs (Avalon slave bus),
//           in_port[WIDTH-1:0] (async pins), irq (registered level).
module nios_interrupt_pio_in
    import nios_interrupt_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    nios_interrupt_pio_in_if.slave  avs,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_param_err
        $error("nios_interrupt_pio_in: WIDTH must be 1..32, EDGE_TYPE 0..2");
    end

    localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

    // Detection stays blind until the first real level has propagated through
    // the sync (and debounce) path and into prev, so pins that are already
    // high when reset releases are not seen as edges.
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int ARM_LEN = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_LEN + 1);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] irq_mask;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        nios_interrupt_pio_sync #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .pin   (in_port[i]),
            .level (level[i])
        );
    end

    assign armed   = (arm_cnt == ARM_W'(ARM_LEN));
    assign wr_en   = avs.chipselect && !avs.write_n;
    assign wr_mask = wr_en && (avs.address == ADDR_IRQ_MASK);
    assign wr_cap  = wr_en && (avs.address == ADDR_EDGE_CAP);

    always_comb begin
        edges = '0;
        case (ETYPE)
            EDGE_RISING:  edges = level & ~prev;
            EDGE_FALLING: edges = ~level & prev;
            EDGE_ANY:     edges = level ^ prev;
            default:      edges = '0;
        endcase
    end

    // A new edge is OR-ed in after the W1C clear, so it survives a clear of
    // the same bit in the same cycle.
    always_comb begin
        edge_cap_next = edge_cap;
        if (wr_cap) begin
            edge_cap_next = edge_cap & ~avs.writedata[WIDTH-1:0];
        end
        if (armed) begin
            edge_cap_next = edge_cap_next | edges;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt  <= '0;
            prev     <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            prev     <= level;
            edge_cap <= edge_cap_next;
            if (wr_mask) begin
                irq_mask <= avs.writedata[WIDTH-1:0];
            end
            // Follows the capture register by one clock.
            irq <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        avs.readdata = '0;
        if (!reset) begin
            case (avs.address)
                ADDR_DATA:     avs.readdata[WIDTH-1:0] = level;
                ADDR_IRQ_MASK: avs.readdata[WIDTH-1:0] = irq_mask;
                ADDR_EDGE_CAP: avs.readdata[WIDTH-1:0] = edge_cap;
                default:       avs.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_interrupt_pio_in.sv
// Purpose : self-checking bench for nios_interrupt_pio_in (rising and any-edge
//           instances share pins and bus), checked against a cycle-history model.
// Latency : n/a.
// Backpress: n/a.
module tb_nios_interrupt_pio_in;
    import nios_interrupt_pio_pkg::*;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 16;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DX = D;
`else
    localparam int DX = 0;
`endif
    localparam int L    = S + DX;      // edges from pin change to DATA
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pins = 4'h0;
    logic [1:0]  b_addr = 2'd0;
    logic        b_cs = 1'b0;
    logic        b_wn = 1'b1;
    logic [31:0] b_wd = 32'h0;
    logic        irq_r;
    logic        irq_a;

    nios_interrupt_pio_in_if bus_r ();
    nios_interrupt_pio_in_if bus_a ();

    assign bus_r.address    = b_addr;
    assign bus_r.chipselect = b_cs;
    assign bus_r.write_n    = b_wn;
    assign bus_r.writedata  = b_wd;
    assign bus_a.address    = b_addr;
    assign bus_a.chipselect = b_cs;
    assign bus_a.write_n    = b_wn;
    assign bus_a.writedata  = b_wd;

    nios_interrupt_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_r (
        .clk (clk), .reset (reset), .avs (bus_r), .in_port (pins), .irq (irq_r));
    nios_interrupt_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_a (
        .clk (clk), .reset (reset), .avs (bus_a), .in_port (pins), .irq (irq_a));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[k] = pin value sampled by the k-th clock edge after reset release.
    int          cyc;
    logic [3:0]  hist     [0:MAXC];
    logic [3:0]  acc_hist [0:MAXC];
    logic [3:0]  m_cap    [2];
    logic [3:0]  m_mask;
    logic        m_irq    [2];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [3:0] synced(int n);
        if (n - S + 1 >= 1) return hist[n - S + 1];
        return 4'h0;
    endfunction

    function automatic logic [3:0] level(int n);
        if (n <= 0) return 4'h0;
`ifdef PIO_IN_DEBOUNCE_EN
        return acc_hist[n];
`else
        return synced(n);
`endif
    endfunction

    function automatic logic [3:0] edge_of(int kind, logic [3:0] cur, logic [3:0] old);
        if (kind == 0) return cur & ~old;
        return cur ^ old;
    endfunction

    function automatic logic [31:0] exp_rd(int d, logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, level(cyc)};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_cap[d]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        cyc         = 0;
        acc_hist[0] = 4'h0;
        m_mask      = 4'h0;
        for (int d = 0; d < 2; d++) begin
            m_cap[d] = 4'h0;
            m_irq[d] = 1'b0;
        end
    endtask

    // One clock: wait for the edge, advance the model with the inputs that
    // edge saw, return at the following falling edge.
    task automatic step();
        logic       wr;
        logic [3:0] c;
        logic       v;
        logic       ok;
        @(posedge clk);
        wr  = b_cs && !b_wn;
        cyc = cyc + 1;
        if (cyc >= MAXC) begin
            $display("FAIL model_history: cycle %0d exceeds history limit %0d", cyc, MAXC);
            $fatal(1);
        end
        hist[cyc] = pins;
        acc_hist[cyc] = acc_hist[cyc - 1];
        // A bit is accepted once the synced stream has held the new value
        // for D consecutive edges.
        for (int b = 0; b < 4; b++) begin
            v  = synced(cyc - 1)[b];
            ok = 1'b1;
            for (int k = cyc - D; k <= cyc - 1; k++)
                if (synced(k)[b] != v) ok = 1'b0;
            if (ok && v != acc_hist[cyc - 1][b]) acc_hist[cyc][b] = v;
        end
        for (int d = 0; d < 2; d++) begin
            m_irq[d] = |(m_cap[d] & m_mask);
            c = m_cap[d];
            if (wr && b_addr == 2'd3) c = c & ~b_wd[3:0];
            if (cyc >= S + 2 + DX) c = c | edge_of(d == 0 ? 0 : 2, level(cyc - 1), level(cyc - 2));
            m_cap[d] = c;
        end
        if (wr && b_addr == 2'd2) m_mask = b_wd[3:0];
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        b_addr = a; b_wd = d; b_cs = 1'b1; b_wn = 1'b0;
        step();
        b_cs = 1'b0; b_wn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; pins = 4'hF; b_cs = 1'b0; b_wn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            b_addr = a[1:0];
            #1;
            checks++;
            if (bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_readdata addr %0d: got %h/%h expected 0", a, bus_r.readdata, bus_a.readdata);
            end
        end
        checks++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b/%b expected 0", irq_r, irq_a);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (10 + DX) step();
        b_addr = 2'd0; #1;
        checks++;
        if (bus_r.readdata !== 32'hF || bus_a.readdata !== 32'hF) begin
            errors++;
            $display("FAIL post_reset_data: got %h/%h expected f", bus_r.readdata, bus_a.readdata);
        end
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_no_capture: got %h/%h expected 0", bus_r.readdata, bus_a.readdata);
        end
        checks++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_irq: got %b/%b expected 0", irq_r, irq_a);
        end
    endtask

    task automatic test_rise_irq();
        pins = 4'h0;
        repeat (L + 4) step();
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'h2);
        pins[1] = 1'b1;
        b_addr = 2'd3;
        for (int k = 1; k <= L + 2; k++) begin
            step();
            #1;
            checks++;
            if (bus_r.readdata !== ((k >= L + 1) ? 32'h2 : 32'h0)) begin
                errors++;
                $display("FAIL rise_capture edge %0d: got %h expected %h", k, bus_r.readdata, (k >= L + 1) ? 32'h2 : 32'h0);
            end
            checks++;
            if (irq_r !== (k >= L + 2)) begin
                errors++;
                $display("FAIL rise_irq edge %0d: got %b expected %b", k, irq_r, k >= L + 2);
            end
        end
        bus_wr(2'd3, 32'h2);
        step();
        checks++;
        if (irq_r !== 1'b0 || irq_r !== m_irq[0]) begin
            errors++;
            $display("FAIL w1c_irq_drop: got %b expected 0", irq_r);
        end
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h0) begin
            errors++;
            $display("FAIL w1c_cleared: got %h expected 0", bus_r.readdata);
        end
    endtask

    task automatic test_mask_late();
        bus_wr(2'd2, 32'h0);
        pins[0] = 1'b1;
        repeat (L + 4) step();
        b_addr = 2'd3; #1;
        checks++;
        if (irq_r !== 1'b0 || bus_r.readdata !== 32'h1) begin
            errors++;
            $display("FAIL masked_capture: irq %b cap %h expected irq 0 cap 1", irq_r, bus_r.readdata);
        end
        bus_wr(2'd2, 32'h1);
        step();
        checks++;
        if (irq_r !== 1'b1 || irq_a !== m_irq[1]) begin
            errors++;
            $display("FAIL unmask_irq: got %b/%b expected 1/%b", irq_r, irq_a, m_irq[1]);
        end
    endtask

    task automatic test_clear_collision();
        pins[2] = 1'b1; pins[0] = 1'b0;
        repeat (L + 4) step();
        pins[0] = 1'b1;
        repeat (L) step();
        bus_wr(2'd3, 32'h5);      // lands on the edge that captures bit0 again
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h1) begin
            errors++;
            $display("FAIL clear_vs_edge_r: got %h expected 1", bus_r.readdata);
        end
        checks++;
        if (bus_a.readdata !== exp_rd(1, 2'd3)) begin
            errors++;
            $display("FAIL clear_vs_edge_a: got %h expected %h", bus_a.readdata, exp_rd(1, 2'd3));
        end
    endtask

    task automatic test_any_edge();
        pins[3] = 1'b1;
        repeat (L + 4) step();
        bus_wr(2'd3, 32'hF);
        for (int t = 0; t < 2; t++) begin
            pins[3] = (t == 1);
            repeat (L + 1) step();
            b_addr = 2'd3; #1;
            checks++;
            if (bus_a.readdata !== 32'h8 || bus_r.readdata !== exp_rd(0, 2'd3)) begin
                errors++;
                $display("FAIL any_edge transition %0d: got %h/%h expected 8/%h", t, bus_a.readdata, bus_r.readdata, exp_rd(0, 2'd3));
            end
            bus_wr(2'd3, 32'h8);
            step();
        end
        bus_wr(2'd1, 32'hFFFF_FFFF);
        b_addr = 2'd1; b_cs = 1'b1; #1;
        checks++;
        if (bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
            errors++;
            $display("FAIL addr1_zero: got %h/%h expected 0", bus_r.readdata, bus_a.readdata);
        end
        b_cs = 1'b0;
        bus_wr(2'd2, 32'hFFFF_FFFF);
        b_addr = 2'd2; #1;
        checks++;
        if (bus_r.readdata !== 32'hF || bus_a.readdata !== 32'hF) begin
            errors++;
            $display("FAIL mask_upper_zero: got %h/%h expected f", bus_r.readdata, bus_a.readdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) pins[b] = ~pins[b];
            b_addr = 2'($urandom_range(0, 3));
            b_cs   = ($urandom_range(0, 1) == 1);
            b_wn   = ($urandom_range(0, 3) != 0);
            b_wd   = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ((d == 0 ? bus_r.readdata : bus_a.readdata) !== exp_rd(d, b_addr)) begin
                    errors++;
                    $display("FAIL random_read dut %0d cyc %0d addr %0d: got %h expected %h", d, cyc, b_addr,
                             d == 0 ? bus_r.readdata : bus_a.readdata, exp_rd(d, b_addr));
                end
                checks++;
                if ((d == 0 ? irq_r : irq_a) !== m_irq[d]) begin
                    errors++;
                    $display("FAIL random_irq dut %0d cyc %0d: got %b expected %b", d, cyc, d == 0 ? irq_r : irq_a, m_irq[d]);
                end
            end
            step();
        end
        b_cs = 1'b0; b_wn = 1'b1;
    endtask

    task automatic test_reset_mid();
        pins = 4'hB;
        bus_wr(2'd2, 32'hF);
        b_addr = 2'd3;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0 || bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: irq %b/%b cap %h/%h expected all 0", irq_r, irq_a, bus_r.readdata, bus_a.readdata);
        end
        @(negedge clk); @(negedge clk);
        model_reset();
        reset = 1'b0;
        repeat (L + 6) step();
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
            errors++;
            $display("FAIL rearm_no_capture: got %h/%h expected 0", bus_r.readdata, bus_a.readdata);
        end
        b_addr = 2'd0; #1;
        checks++;
        if (bus_r.readdata !== 32'hB || bus_a.readdata !== exp_rd(1, 2'd0)) begin
            errors++;
            $display("FAIL rearm_data: got %h/%h expected b", bus_r.readdata, bus_a.readdata);
        end
    endtask

`ifdef PIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        pins = 4'h0;
        repeat (L + 4) step();
        bus_wr(2'd3, 32'hF);
        pins[0] = 1'b1;
        repeat (10) step();
        pins[0] = 1'b0;
        repeat (L + 10) step();
        b_addr = 2'd0; #1;
        checks++;
        if (bus_r.readdata !== 32'h0) begin
            errors++;
            $display("FAIL glitch_data: got %h expected 0", bus_r.readdata);
        end
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h0 || bus_a.readdata !== 32'h0) begin
            errors++;
            $display("FAIL glitch_capture: got %h/%h expected 0", bus_r.readdata, bus_a.readdata);
        end
        pins[0] = 1'b1;
        b_addr = 2'd0;
        repeat (S + D - 1) step();
        #1;
        checks++;
        if (bus_r.readdata !== 32'h0) begin
            errors++;
            $display("FAIL debounce_early: got %h expected 0", bus_r.readdata);
        end
        step(); #1;
        checks++;
        if (bus_r.readdata !== 32'h1) begin
            errors++;
            $display("FAIL debounce_accept: got %h expected 1", bus_r.readdata);
        end
        repeat (20 - (S + D)) step();
        pins[0] = 1'b0;
        repeat (4) step();
        b_addr = 2'd3; #1;
        checks++;
        if (bus_r.readdata !== 32'h1 || bus_a.readdata !== exp_rd(1, 2'd3)) begin
            errors++;
            $display("FAIL debounce_capture: got %h/%h expected 1/%h", bus_r.readdata, bus_a.readdata, exp_rd(1, 2'd3));
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_rise_irq();
        test_mask_late();
        test_clear_collision();
        test_any_edge();
        test_random();
        test_reset_mid();
`ifdef PIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
